// File: rtl/vco_adc_pkg.sv
// Shared constants and types for the VCO ADC datapath.
package vco_adc_pkg;

    localparam int unsigned OUT_W_DEFAULT  = 32;
    localparam int unsigned R_W_DEFAULT    = 10;
    localparam int unsigned WARMUP_DEFAULT = 3;
    localparam int unsigned R_MIN          = 2;

    typedef logic [OUT_W_DEFAULT-1:0] cic_word_t;

endpackage

// File: rtl/vco_edge_sync.sv
// Two-flop synchroniser for the VCO phase plus a registered rising-edge detector.
module vco_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic phase_i,
    output logic edge_o
);

    logic sync1_q, sync2_q, hist_q, edge_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= phase_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            edge_q  <= sync2_q & ~hist_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/vco_sinc3_decimator.sv
// Edge-detects the VCO phase and decimates the 1-bit stream with a sinc3 CIC at runtime ratio.
// Define VCO_SINC3_RAW_EN to add raw_cnt_o, the saturating edge count of the last frame.
module vco_sinc3_decimator
    import vco_adc_pkg::*;
#(
    parameter int unsigned OUT_W  = OUT_W_DEFAULT,
    parameter int unsigned R_W    = R_W_DEFAULT,
    parameter int unsigned WARMUP = WARMUP_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             phase_in,
    input  logic             en_i,
    input  logic [R_W-1:0]   oversample_i,
    output logic [OUT_W-1:0] dout_o,
    output logic             dvalid_o
`ifdef VCO_SINC3_RAW_EN
    ,
    output logic [15:0]      raw_cnt_o
`endif
);

    localparam int unsigned WuW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
    localparam logic [R_W-1:0] RMin = R_W'(R_MIN);

    typedef logic [OUT_W-1:0] word_t;

    logic s;

    vco_edge_sync u_edge_sync (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .phase_i (phase_in),
        .edge_o  (s)
    );

    word_t i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    word_t d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    word_t dout_q, dout_d;
    word_t c1, c2, c3;
    logic  dvalid_q, dvalid_d;
    logic [R_W-1:0] dcnt_q, dcnt_d, rl_q, rl_d, osr_clamped;
    logic [WuW-1:0] wu_q, wu_d;
    logic           boundary;

`ifdef VCO_SINC3_RAW_EN
    logic [15:0] raw_acc_q, raw_acc_d, raw_cnt_q, raw_cnt_d, raw_inc;
`endif

    assign c1 = i3_q - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;

    assign osr_clamped = (oversample_i < RMin) ? RMin : oversample_i;
    // rl_q >= 2 always, so a stale rl_q on the frame's first cycle can never fake a boundary.
    assign boundary    = en_i && (dcnt_q == (rl_q - R_W'(1)));

    always_comb begin
        i1_d     = i1_q;
        i2_d     = i2_q;
        i3_d     = i3_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        dcnt_d   = dcnt_q;
        rl_d     = rl_q;
        wu_d     = wu_q;

        if (dcnt_q == '0) begin
            rl_d = osr_clamped;
        end

        if (!en_i) begin
            i1_d   = '0;
            i2_d   = '0;
            i3_d   = '0;
            d1_d   = '0;
            d2_d   = '0;
            d3_d   = '0;
            dcnt_d = '0;
            wu_d   = '0;
        end else begin
            i1_d = i1_q + {{(OUT_W-1){1'b0}}, s};
            i2_d = i2_q + i1_q;
            i3_d = i3_q + i2_q;
            if (boundary) begin
                dcnt_d = '0;
                d1_d   = i3_q;
                d2_d   = c1;
                d3_d   = c2;
                if (wu_q < WuW'(WARMUP)) begin
                    wu_d = wu_q + WuW'(1);
                end else begin
                    dout_d   = c3;
                    dvalid_d = 1'b1;
                end
            end else begin
                dcnt_d = dcnt_q + R_W'(1);
            end
        end
    end

`ifdef VCO_SINC3_RAW_EN
    assign raw_inc = (s && (raw_acc_q != 16'hFFFF)) ? raw_acc_q + 16'd1 : raw_acc_q;

    always_comb begin
        raw_acc_d = raw_acc_q;
        raw_cnt_d = raw_cnt_q;
        if (!en_i) begin
            raw_acc_d = '0;
        end else if (boundary) begin
            raw_acc_d = '0;
            if (dvalid_d) begin
                raw_cnt_d = raw_inc;
            end
        end else begin
            raw_acc_d = raw_inc;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            raw_acc_q <= '0;
            raw_cnt_q <= '0;
        end else begin
            raw_acc_q <= raw_acc_d;
            raw_cnt_q <= raw_cnt_d;
        end
    end

    assign raw_cnt_o = raw_cnt_q;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            dcnt_q   <= '0;
            rl_q     <= RMin;
            wu_q     <= '0;
        end else begin
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            i3_q     <= i3_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dcnt_q   <= dcnt_d;
            rl_q     <= rl_d;
            wu_q     <= wu_d;
        end
    end

    assign dout_o   = dout_q;
    assign dvalid_o = dvalid_q;

endmodule

// File: tb/tb_vco_sinc3_decimator.sv
// Directed bench for vco_sinc3_decimator: table of ratio/input cases plus corner sequences.
module tb_vco_sinc3_decimator;
    import vco_adc_pkg::*;

    localparam int unsigned OUT_W = 32;
    localparam int unsigned R_W   = 10;

    logic             clk = 1'b0;
    logic             wb_rst_i;
    logic             phase_in;
    logic             en_i;
    logic [R_W-1:0]   oversample_i;
    cic_word_t        dout_o;
    logic             dvalid_o;
`ifdef VCO_SINC3_RAW_EN
    logic [15:0]      raw_cnt_o;
`endif

    always #5 clk = ~clk;

    vco_sinc3_decimator #(
        .OUT_W  (OUT_W),
        .R_W    (R_W),
        .WARMUP (3)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (wb_rst_i),
        .phase_in     (phase_in),
        .en_i         (en_i),
        .oversample_i (oversample_i),
        .dout_o       (dout_o),
        .dvalid_o     (dvalid_o)
`ifdef VCO_SINC3_RAW_EN
        ,
        .raw_cnt_o    (raw_cnt_o)
`endif
    );

    typedef struct {
        int osr;
        int half;
        int per;
        int exp_dout;
    } vec_t;

    vec_t vecs[9];
    int   total = 0;
    int   bad   = 0;
    int   ph_half = 0;

    // Square-wave source: toggles every ph_half clocks, held low when ph_half is 0.
    initial begin
        int ph_cnt;
        phase_in = 1'b0;
        ph_cnt   = 0;
        forever begin
            @(posedge clk);
            #2;
            if (ph_half == 0) begin
                phase_in = 1'b0;
                ph_cnt   = 0;
            end else begin
                ph_cnt++;
                if (ph_cnt >= ph_half) begin
                    ph_cnt   = 0;
                    phase_in = ~phase_in;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            tick();
            n++;
            if (dvalid_o === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic start(input int osr, input int half);
        en_i         = 1'b0;
        oversample_i = R_W'(osr);
        ph_half      = half;
        repeat (12) tick();
        en_i = 1'b1;
    endtask

    task automatic run_case(input int k, input vec_t v);
        int n;
        bit ok;
        start(v.osr, v.half);
        wait_strobe(4 * v.per + 8, n, ok);
        check($sformatf("v%0d first latency", k), n, 4 * v.per);
        check($sformatf("v%0d first dout", k), dout_o, v.exp_dout);
        for (int j = 0; j < 3; j++) begin
            wait_strobe(v.per + 4, n, ok);
            check($sformatf("v%0d period %0d", k, j), n, v.per);
            check($sformatf("v%0d dout %0d", k, j), dout_o, v.exp_dout);
`ifdef VCO_SINC3_RAW_EN
            check($sformatf("v%0d raw %0d", k, j), 32'(raw_cnt_o),
                  (v.half == 0) ? 0 : v.per / (2 * v.half));
`endif
        end
    endtask

    initial begin
        int n;
        bit ok;
        int vals[5];

        vecs[0] = '{8, 0, 8, 0};
        vecs[1] = '{8, 2, 8, 128};
        vecs[2] = '{16, 2, 16, 1024};
        vecs[3] = '{4, 2, 4, 16};
        vecs[4] = '{8, 4, 8, 64};
        vecs[5] = '{12, 2, 12, 432};
        vecs[6] = '{16, 4, 16, 512};
        vecs[7] = '{0, 0, 2, 0};
        vecs[8] = '{1, 0, 2, 0};

        wb_rst_i     = 1'b1;
        en_i         = 1'b0;
        oversample_i = R_W'(8);
        repeat (3) tick();
        check("reset dout", dout_o, 0);
        check("reset dvalid", 32'(dvalid_o), 0);
`ifdef VCO_SINC3_RAW_EN
        check("reset raw", 32'(raw_cnt_o), 0);
`endif
        wb_rst_i = 1'b0;

        for (int k = 0; k < 9; k++) run_case(k, vecs[k]);

        // R clamped to 2 with a period-4 input: outputs alternate 1/3, averaging 2.
        start(0, 2);
        wait_strobe(16, n, ok);
        check("r2 first latency", n, 8);
        vals[0] = int'(dout_o);
        for (int j = 1; j < 5; j++) begin
            wait_strobe(6, n, ok);
            check("r2 period", n, 2);
            vals[j] = int'(dout_o);
        end
        for (int j = 0; j < 4; j++) begin
            check("r2 pair sum", vals[j] + vals[j + 1], 4);
            check("r2 value set", 32'(vals[j] == 1 || vals[j] == 3), 1);
        end

        // Ratio change 8 -> 16 three cycles into a frame.
        start(8, 2);
        wait_strobe(40, n, ok);
        check("rchg first latency", n, 32);
        wait_strobe(12, n, ok);
        check("rchg period 8", n, 8);
        repeat (3) tick();
        oversample_i = R_W'(16);
        wait_strobe(12, n, ok);
        check("rchg old frame end", n, 5);
        for (int j = 0; j < 4; j++) begin
            wait_strobe(20, n, ok);
            check($sformatf("rchg period16 %0d", j), n, 16);
        end
        check("rchg settled dout", dout_o, 1024);

        // Enable dropped for 5 cycles mid-frame.
        repeat (3) tick();
        en_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("en low dvalid", 32'(dvalid_o), 0);
            check("en low dout held", dout_o, 1024);
        end
        en_i = 1'b1;
        wait_strobe(72, n, ok);
        check("reenable latency", n, 64);
        check("reenable dout", dout_o, 1024);

        // Enable dropped exactly on the boundary cycle.
        repeat (15) tick();
        en_i = 1'b0;
        tick();
        check("en drop boundary dvalid", 32'(dvalid_o), 0);
        check("en drop boundary dout", dout_o, 1024);
        repeat (3) tick();
        check("en drop later dvalid", 32'(dvalid_o), 0);
        en_i = 1'b1;
        wait_strobe(72, n, ok);
        check("en drop restart latency", n, 64);

        // Reset mid-frame while running.
        start(8, 2);
        wait_strobe(40, n, ok);
        wait_strobe(12, n, ok);
        check("pre-reset dout", dout_o, 128);
        repeat (3) tick();
        wb_rst_i = 1'b1;
        tick();
        check("midrst dout", dout_o, 0);
        check("midrst dvalid", 32'(dvalid_o), 0);
`ifdef VCO_SINC3_RAW_EN
        check("midrst raw", 32'(raw_cnt_o), 0);
`endif
        wb_rst_i = 1'b0;
        wait_strobe(40, n, ok);
        check("post-reset latency", n, 32);
        check("post-reset dout", dout_o, 128);
`ifdef VCO_SINC3_RAW_EN
        check("post-reset raw", 32'(raw_cnt_o), 2);
`endif
        wait_strobe(12, n, ok);
        check("post-reset period", n, 8);
        check("post-reset dout 2", dout_o, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
